gpi_event_ctrl: RTL and testbench
=================================

GPI_EVENT_CTRL -- requirements
Module: gpi_event_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 8, consecutive stable cycles a synced input needs before the filtered value changes (range 2..15).
REQ-002 SHALL have port PCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port PRESETn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port PADDR  input  5  APB byte address; word offset in [4:2].
REQ-005 SHALL have ports PWRITE, PENABLE, PSEL  input  1 each  APB control.
REQ-006 SHALL have port PWDATA  input  32  APB write data.
REQ-007 SHALL have port PRDATA  output  32  APB read data, registered.
REQ-008 SHALL have port PREADY  output  1  APB ready, registered.
REQ-009 SHALL have port gpi  input  8  asynchronous external inputs.
REQ-010 SHALL have port irq  output  1  registered level interrupt.

Function
REQ-011 Register map (word offset): 0 CR enable RW, 1 IDR filtered input RO, 2 IER interrupt enable RW, 3 EDGE 1=rising/0=falling RW, 4 ISR pending RW1C; each 8 bits, upper 24 bits read 0.
REQ-012 Offsets 5..7 SHALL read 0; writes to them and to IDR SHALL be ignored.
REQ-013 APB access SHALL be acted on in the cycle PSEL&PENABLE&!PREADY; PREADY SHALL be 1 on the following cycle only (one wait state), then return to 0.
REQ-014 Write data and read capture SHALL happen once per access; no action while PREADY=1.
REQ-015 Each gpi bit SHALL pass a two-flop synchronizer (s1, s2) before any use.
REQ-016 Filtered value SHALL equal s2 when GPI_DEBOUNCE_EN is undefined (see REQ-027).
REQ-017 A per-bit previous register SHALL track the filtered value every cycle regardless of CR.
REQ-018 Event on bit i SHALL be filtered[i]!=prev[i] with CR[i]=1 and direction matching EDGE[i].
REQ-019 ISR[i] SHALL set on the edge the event is detected: 3 PCLK edges after gpi[i] changes (no debounce).
REQ-020 Write of 1 to ISR[i] SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-021 Simultaneous event and W1C on the same bit: set SHALL win (ISR[i]=1).
REQ-022 ISR SHALL hold set bits while CR or IER bits are changed; clearing CR[i] SHALL not clear ISR[i].
REQ-023 irq SHALL be registered |(ISR & IER), asserting one cycle after the enabling ISR/IER change.
REQ-024 IDR read SHALL return filtered & CR; disabled bits read 0.

Reset
REQ-025 On PRESETn=0 asynchronously: CR, IER, EDGE, ISR, PRDATA, irq, PREADY = 0; s1, s2, prev, filtered, debounce counters = 0.
REQ-026 Reset asserted mid-access SHALL abort it; first access after release SHALL complete normally; no event SHALL fire from reset release alone while gpi=0.

Configuration
REQ-027 Macro GPI_DEBOUNCE_EN defined: per-bit 4-bit counter counts cycles with s2!=filtered, resets to 0 when equal; filtered toggles when count reaches DEB_CYCLES-1, adding DEB_CYCLES cycles of latency; glitches shorter than DEB_CYCLES cycles SHALL produce no event. Undefined: no counters, filtered=s2.

Verification
REQ-028 Reset, read all offsets 0..7 -> all PRDATA=0x0, PREADY high exactly 1 cycle per access, irq=0.
REQ-029 CR=0x01, EDGE=0x01, IER=0x01, gpi[0] 0->1 (no debounce) -> ISR=0x01 on 3rd edge, irq=1 on 4th edge; write ISR=0x01 -> irq=0 next cycle.
REQ-030 CR=0x80, EDGE=0x00, gpi[7] 1->0 and gpi[6] toggled -> ISR=0x80 only; IDR read with gpi=0x40 returns 0x00.
REQ-031 Event on bit 2 in the same cycle as W1C ISR=0x04 -> ISR[2] stays 1, irq remains asserted with IER=0x04.
REQ-032 GPI_DEBOUNCE_EN, DEB_CYCLES=8: 5-cycle pulse on gpi[1] -> no ISR change; 20-cycle pulse -> ISR[1]=1 at 3+8 edges after rise.
REQ-033 PRESETn low during write access to IER=0xFF -> IER=0x00 after release, next access to IER=0x0F completes with PREADY 1 cycle.

Source files
------------

// File: rtl/gpi_event_ctrl.sv
// gpi_event_ctrl: APB-attached general purpose input block with per-bit edge
// event capture, W1C pending register and a registered level interrupt.
// Optional feature macro: GPI_DEBOUNCE_EN. When defined, every synchronized
// input passes a per-bit debounce counter; when undefined, the filtered value
// is the synchronizer output.

package gpi_event_ctrl_pkg;
  // Word offsets of the register map (PADDR[4:2])
  localparam logic [2:0] OFF_CR   = 3'd0;
  localparam logic [2:0] OFF_IDR  = 3'd1;
  localparam logic [2:0] OFF_IER  = 3'd2;
  localparam logic [2:0] OFF_EDGE = 3'd3;
  localparam logic [2:0] OFF_ISR  = 3'd4;
endpackage

module gpi_event_ctrl
  import gpi_event_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [4:0]  PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic [7:0]  gpi,
  output logic        irq
);

  // Counter value on which the filtered bit finally follows the input
  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic       pready_q;
  logic       access;
  logic       wr_access;
  logic       rd_access;
  logic [2:0] offset;

  // One action per transfer: the cycle after acting, PREADY is high and
  // blocks a second action while the master completes the transfer.
  assign access    = PSEL & PENABLE & ~pready_q;
  assign wr_access = access & PWRITE;
  assign rd_access = access & ~PWRITE;
  assign offset    = PADDR[4:2];

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [7:0] s1_q;
  logic [7:0] s2_q;
  logic [7:0] filtered;

  // Two-flop synchronizer for the asynchronous inputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse s1/s2 into one.
      s1_q <= gpi;
      s2_q <= s1_q;
    end
  end

`ifdef GPI_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Debounce: a bit must differ from the filtered value for DEB_CYCLES
  // consecutive cycles before the filtered value follows it.
  // ---------------------------------------------------------------------------
  logic [3:0] cnt_q [8];
  logic [7:0] filt_q;

  // Per-bit stability counters and the filtered value they gate
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      // NOTE: this counter array is a handful of flops whose start value
      // matters, so it is reset; bulk storage arrays usually are not.
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      filt_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          cnt_q[i]  <= '0;
          filt_q[i] <= s2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign filtered = filt_q;

  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:8]};
`else
  assign filtered = s2_q;

  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:8], DEB_LAST};
`endif

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic [7:0] prev_q;
  logic [7:0] cr_q;
  logic [7:0] edge_sel_q;
  logic [7:0] evt;

  // Previous filtered value, tracked even for disabled bits so that enabling
  // a bit never produces a stale event.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) prev_q <= '0;
    else          prev_q <= filtered;
  end

  // A change whose new level matches the selected direction (1 = rising)
  assign evt = (filtered ^ prev_q) & cr_q & ~(filtered ^ edge_sel_q);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [7:0] cr_d;
  logic [7:0] ier_q;
  logic [7:0] ier_d;
  logic [7:0] edge_sel_d;
  logic [7:0] isr_q;
  logic [7:0] isr_d;
  logic [7:0] w1c;

  // Next-state for the writable registers; a new event wins over W1C
  always_comb begin
    // NOTE: every output of this block gets a default first; otherwise the
    // offsets that do not write a register would infer latches.
    cr_d       = cr_q;
    ier_d      = ier_q;
    edge_sel_d = edge_sel_q;
    w1c        = '0;
    if (wr_access) begin
      case (offset)
        OFF_CR:   cr_d       = PWDATA[7:0];
        OFF_IER:  ier_d      = PWDATA[7:0];
        OFF_EDGE: edge_sel_d = PWDATA[7:0];
        OFF_ISR:  w1c        = PWDATA[7:0];
        default:  ;
      endcase
    end
    isr_d = (isr_q & ~w1c) | evt;
  end

  // Control and pending registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cr_q       <= '0;
      ier_q      <= '0;
      edge_sel_q <= '0;
      isr_q      <= '0;
    end else begin
      cr_q       <= cr_d;
      ier_q      <= ier_d;
      edge_sel_q <= edge_sel_d;
      isr_q      <= isr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path, ready and interrupt
  // ---------------------------------------------------------------------------
  logic [7:0]  rdata_sel;
  logic [31:0] prdata_q;
  logic [31:0] prdata_d;
  logic        irq_q;

  // Read mux; IDR only shows enabled bits, unmapped offsets read zero
  always_comb begin
    rdata_sel = '0;
    case (offset)
      OFF_CR:   rdata_sel = cr_q;
      OFF_IDR:  rdata_sel = filtered & cr_q;
      OFF_IER:  rdata_sel = ier_q;
      OFF_EDGE: rdata_sel = edge_sel_q;
      OFF_ISR:  rdata_sel = isr_q;
      default:  rdata_sel = '0;
    endcase
    prdata_d = rd_access ? {24'h0, rdata_sel} : prdata_q;
  end

  // Registered APB response and level interrupt
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prdata_q <= '0;
      pready_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      prdata_q <= prdata_d;
      pready_q <= access;
      irq_q    <= |(isr_q & ier_q);
    end
  end

  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_gpi_event_ctrl.sv
// tb_gpi_event_ctrl: table-driven register checks, hand-written timing
// sequences and a randomized phase against a behavioural model.
module tb_gpi_event_ctrl;

  localparam int DEB = 8;
`ifdef GPI_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  localparam logic [2:0] O_CR = 3'd0, O_IDR = 3'd1, O_IER = 3'd2,
                         O_EDGE = 3'd3, O_ISR = 3'd4;

  logic        PCLK;
  logic        PRESETn;
  logic [4:0]  PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [7:0]  gpi;
  logic        irq;

  gpi_event_ctrl #(.DEB_CYCLES(DEB)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .gpi(gpi), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int tests = 0;
  int fails = 0;
  bit rand_gpi = 1'b0;

  // Behavioural model: inputs are seen two edges late, events are level
  // changes of that delayed view in the enabled direction.
  logic [7:0]  m_d0, m_d1, m_filt, m_prev, m_cr, m_ier, m_edge, m_isr;
  logic        m_irq, m_pready;
  logic [31:0] m_prdata;
  int          m_run [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_filtered();
`ifdef GPI_DEBOUNCE_EN
    return m_filt;
`else
    return m_d1;
`endif
  endfunction

  task automatic model_edge();
    logic [7:0] f, ev, w1c, rsel;
    logic       acc;
    logic [2:0] off;
    if (!PRESETn) begin
      m_d0 = 0; m_d1 = 0; m_filt = 0; m_prev = 0; m_cr = 0; m_ier = 0;
      m_edge = 0; m_isr = 0; m_irq = 0; m_pready = 0; m_prdata = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      return;
    end
    f   = m_filtered();
    acc = PSEL && PENABLE && !m_pready;
    off = PADDR[4:2];
    ev  = (f ^ m_prev) & m_cr & ~(f ^ m_edge);
    w1c = (acc && PWRITE && off == O_ISR) ? PWDATA[7:0] : 8'h00;
    m_irq = |(m_isr & m_ier);
    if (acc && !PWRITE) begin
      case (off)
        O_CR:    rsel = m_cr;
        O_IDR:   rsel = f & m_cr;
        O_IER:   rsel = m_ier;
        O_EDGE:  rsel = m_edge;
        O_ISR:   rsel = m_isr;
        default: rsel = 8'h00;
      endcase
      m_prdata = {24'h0, rsel};
    end
    if (acc && PWRITE) begin
      if (off == O_CR)   m_cr   = PWDATA[7:0];
      if (off == O_IER)  m_ier  = PWDATA[7:0];
      if (off == O_EDGE) m_edge = PWDATA[7:0];
    end
    m_isr    = (m_isr & ~w1c) | ev;
    m_prev   = f;
    m_pready = acc;
    for (int i = 0; i < 8; i++) begin
      if (m_d1[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_filt[i] = m_d1[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d1 = m_d0;
    m_d0 = gpi;
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare
  task automatic step();
    if (rand_gpi && $urandom_range(0, 5) == 0) gpi = gpi ^ 8'($urandom);
    model_edge();
    @(posedge PCLK);
    #1;
    check("pready", {31'h0, PREADY}, {31'h0, m_pready});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    check("prdata", PRDATA, m_prdata);
  endtask

  task automatic apb(input bit wr, input logic [2:0] off, input logic [31:0] wd,
                     output logic [31:0] rd);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PWDATA = wd;
    PADDR = {off, 2'($urandom_range(0, 3))};
    step();
    PENABLE = 1'b1;
    step();
    check("pready_high", {31'h0, PREADY}, 32'h1);
    rd = PRDATA;
    step();
    check("pready_low", {31'h0, PREADY}, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; gpi = 0;
    PRESETn = 1'b0;
    step();
    step();
    PRESETn = 1'b1;
    step();
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [2:0] off, logic [31:0] wd, logic [31:0] exp);
    vec_t v;
    v.wr = wr; v.off = off; v.wdata = wd; v.exp = exp;
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;

    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; gpi = 0;

    // Reset state and register map
    for (int o = 0; o < 8; o++) vecs.push_back(mk(1'b0, 3'(o), 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, O_CR,   32'hFFFF_FF5A, 32'h0));
    vecs.push_back(mk(1'b0, O_CR,   32'h0,         32'h5A));
    vecs.push_back(mk(1'b1, O_IER,  32'h0000_003C, 32'h0));
    vecs.push_back(mk(1'b0, O_IER,  32'h0,         32'h3C));
    vecs.push_back(mk(1'b1, O_EDGE, 32'h1234_56A5, 32'h0));
    vecs.push_back(mk(1'b0, O_EDGE, 32'h0,         32'hA5));
    vecs.push_back(mk(1'b1, O_IDR,  32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(1'b0, O_IDR,  32'h0,         32'h00));
    vecs.push_back(mk(1'b1, 3'd5,   32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(1'b0, 3'd5,   32'h0,         32'h00));
    vecs.push_back(mk(1'b1, 3'd7,   32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(1'b0, 3'd7,   32'h0,         32'h00));
    vecs.push_back(mk(1'b0, O_CR,   32'h0,         32'h5A));
    vecs.push_back(mk(1'b1, O_ISR,  32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(1'b0, O_ISR,  32'h0,         32'h00));

    do_reset();
    check("reset_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      apb(vecs[i].wr, vecs[i].off, vecs[i].wdata, rd);
      if (!vecs[i].wr) check($sformatf("tbl%0d_off%0d", i, vecs[i].off), rd, vecs[i].exp);
    end

    // Rising event on bit 0: ISR at edge LAT, irq one edge later, W1C clears
    do_reset();
    apb(1, O_CR, 32'h01, rd);
    apb(1, O_EDGE, 32'h01, rd);
    apb(1, O_IER, 32'h01, rd);
    gpi = 8'h01;
    for (int k = 0; k < LAT; k++) step();
    check("irq_before", {31'h0, irq}, 32'h0);
    step();
    check("irq_after", {31'h0, irq}, 32'h1);
    apb(0, O_ISR, 0, rd);
    check("isr_bit0", rd, 32'h01);
    apb(1, O_ISR, 32'h01, rd);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    apb(0, O_ISR, 0, rd);
    check("isr_cleared", rd, 32'h00);

    // Falling edge on enabled bit 7, bit 6 disabled
    do_reset();
    gpi = 8'h80;
    for (int k = 0; k < LAT + 2; k++) step();
    apb(1, O_CR, 32'h80, rd);
    apb(1, O_EDGE, 32'h00, rd);
    gpi = 8'h40;
    for (int k = 0; k < LAT + 2; k++) step();
    apb(0, O_ISR, 0, rd);
    check("isr_fall7", rd, 32'h80);
    apb(0, O_IDR, 0, rd);
    check("idr_masked", rd, 32'h00);
    apb(1, O_CR, 32'hC0, rd);
    apb(0, O_IDR, 0, rd);
    check("idr_bit6", rd, 32'h40);
    apb(1, O_CR, 32'h00, rd);
    apb(0, O_ISR, 0, rd);
    check("isr_hold_cr0", rd, 32'h80);

    // Event on bit 2 lands on the same edge as its W1C
    do_reset();
    apb(1, O_CR, 32'h04, rd);
    apb(1, O_EDGE, 32'h04, rd);
    apb(1, O_IER, 32'h04, rd);
    gpi = 8'h04;
    for (int k = 0; k < LAT + 1; k++) step();
    check("irq_bit2", {31'h0, irq}, 32'h1);
    gpi = 8'h00;
    for (int k = 0; k < LAT + 2; k++) step();
    gpi = 8'h04;
    for (int k = 0; k < LAT - 2; k++) step();
    apb(1, O_ISR, 32'h04, rd);
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    apb(0, O_ISR, 0, rd);
    check("isr_set_wins", rd, 32'h04);
    apb(1, O_ISR, 32'h04, rd);
    apb(0, O_ISR, 0, rd);
    check("isr_plain_w1c", rd, 32'h00);
    check("irq_plain_w1c", {31'h0, irq}, 32'h0);

`ifdef GPI_DEBOUNCE_EN
    // Short glitch filtered out, long pulse accepted after DEB cycles
    do_reset();
    apb(1, O_CR, 32'h02, rd);
    apb(1, O_EDGE, 32'h02, rd);
    apb(1, O_IER, 32'h02, rd);
    gpi = 8'h02;
    for (int k = 0; k < 5; k++) step();
    gpi = 8'h00;
    for (int k = 0; k < 30; k++) step();
    apb(0, O_ISR, 0, rd);
    check("deb_glitch", rd, 32'h00);
    gpi = 8'h02;
    for (int k = 0; k < LAT; k++) step();
    check("deb_irq_before", {31'h0, irq}, 32'h0);
    step();
    check("deb_irq_after", {31'h0, irq}, 32'h1);
    for (int k = 0; k < 20 - (LAT + 1); k++) step();
    gpi = 8'h00;
    apb(0, O_ISR, 0, rd);
    check("deb_isr", rd, 32'h02);
`endif

    // Reset in the middle of a write to IER aborts it
    do_reset();
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = {O_IER, 2'b00}; PWDATA = 32'hFF;
    step();
    PENABLE = 1;
    #2;
    PRESETn = 1'b0;
    step();
    step();
    PSEL = 0; PENABLE = 0;
    PRESETn = 1'b1;
    step();
    apb(0, O_IER, 0, rd);
    check("ier_aborted", rd, 32'h00);
    apb(1, O_IER, 32'h0F, rd);
    apb(0, O_IER, 0, rd);
    check("ier_after_rst", rd, 32'h0F);

    // Randomized traffic against the model
    do_reset();
    rand_gpi = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) < 3) step();
      else apb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, rd);
    end
    rand_gpi = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
